tcam_match_walker: RTL and testbench

Downstream consumer of the TCAM `matched` vector. Captures one match vector per lookup and serialises the set bits into a stream of entry indices, one per accepted handshake, in priority order. Reports the hit count and a miss pulse for all-zero vectors. Feeds the action/result table that is addressed by TCAM entry index.

---
 rtl/tcam_match_walker_if.sv | 26 ++
 rtl/tcam_match_walker.sv | 116 +++++++++++
 tb/tb_tcam_match_walker.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tcam_match_walker_if.sv
// Handshake bundle between a TCAM match-vector producer/consumer and tcam_match_walker.
// master: drives lookups and idx_ready; slave: the walker.
interface tcam_match_walker_if #(
    parameter int N  = 20,
    parameter int AW = 5
);
    logic          match_valid;
    logic [N-1:0]  matched;
    logic          match_ready;
    logic          idx_valid;
    logic [AW-1:0] idx;
    logic          idx_last;
    logic          idx_ready;
    logic [AW:0]   hit_count;
    logic          miss;

    modport master (
        output match_valid, matched, idx_ready,
        input  match_ready, idx_valid, idx, idx_last, hit_count, miss
    );

    modport slave (
        input  match_valid, matched, idx_ready,
        output match_ready, idx_valid, idx, idx_last, hit_count, miss
    );
endinterface

// File: rtl/tcam_match_walker.sv
// Captures one TCAM match vector and serialises its set bits into entry indices.
// Define TCAM_WALK_MSB_FIRST_EN to emit indices highest-first instead of lowest-first.
module tcam_match_walker #(
    parameter int N  = 20,
    parameter int AW = 5
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    tcam_match_walker_if.slave   io_walk
);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        WALK
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [N-1:0]  r_pending;
    logic [N-1:0]  w_pending_nxt;
    logic [N-1:0]  w_sel_mask;
    logic [CW-1:0] r_hit_count;
    logic [CW-1:0] w_hit_count_nxt;
    logic [CW-1:0] w_match_pop;
    logic [CW-1:0] w_pend_pop;
    logic          r_miss;
    logic          w_miss_nxt;
    logic [AW-1:0] w_idx;
    logic          w_last;

    always_comb begin
        w_match_pop = '0;
        w_pend_pop  = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_match_pop = w_match_pop + CW'(io_walk.matched[i]);
            w_pend_pop  = w_pend_pop  + CW'(r_pending[i]);
        end
    end

    // Later loop iterations overwrite earlier ones, so the scan direction picks the priority.
    always_comb begin
        w_idx      = '0;
        w_sel_mask = '0;
`ifdef TCAM_WALK_MSB_FIRST_EN
        for (int unsigned i = 0; i < N; i++) begin
            if (r_pending[i]) begin
                w_idx         = AW'(i);
                w_sel_mask    = '0;
                w_sel_mask[i] = 1'b1;
            end
        end
`else
        for (int unsigned k = 0; k < N; k++) begin
            if (r_pending[N-1-k]) begin
                w_idx               = AW'(N - 1 - k);
                w_sel_mask          = '0;
                w_sel_mask[N-1-k]   = 1'b1;
            end
        end
`endif
    end

    assign w_last = (w_pend_pop == CW'(1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_pending   <= '0;
            r_hit_count <= '0;
            r_miss      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pending   <= w_pending_nxt;
            r_hit_count <= w_hit_count_nxt;
            r_miss      <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pending_nxt   = r_pending;
        w_hit_count_nxt = r_hit_count;
        w_miss_nxt      = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_walk.match_valid) begin
                    w_pending_nxt   = io_walk.matched;
                    w_hit_count_nxt = w_match_pop;
                    if (io_walk.matched == '0) begin
                        w_miss_nxt = 1'b1;
                    end else begin
                        w_state_nxt = WALK;
                    end
                end
            end
            WALK: begin
                if (io_walk.idx_ready) begin
                    w_pending_nxt = r_pending & ~w_sel_mask;
                    if (w_last) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // pending is zero whenever IDLE, so idx/idx_last read 0 there without extra gating.
    assign io_walk.match_ready = (r_state == IDLE);
    assign io_walk.idx_valid   = (r_state == WALK);
    assign io_walk.idx         = w_idx;
    assign io_walk.idx_last    = w_last;
    assign io_walk.hit_count   = r_hit_count;
    assign io_walk.miss        = r_miss;
endmodule

// File: tb/tb_tcam_match_walker.sv
// Scoreboard bench for tcam_match_walker: stimulus queues expected indices, a negedge monitor checks transfers.
module tb_tcam_match_walker;
    localparam int N  = 20;
    localparam int AW = 5;

    typedef struct {
        int idx;
        int last;
        int hc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];

    tcam_match_walker_if #(.N(N), .AW(AW)) bus ();

    tcam_match_walker #(.N(N), .AW(AW)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_walk (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int last, input int hc);
        exp_t e;
        e.idx  = idx;
        e.last = last;
        e.hc   = hc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && bus.idx_valid === 1'b1 && bus.idx_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_idx: got idx %0d, expected no transfer (t=%0t)", bus.idx, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_idx",       32'(bus.idx),       e.idx);
                chk("xfer_idx_last",  32'(bus.idx_last),  e.last);
                chk("xfer_hit_count", 32'(bus.hit_count), e.hc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        bus.match_valid = 1'b0;
        bus.matched     = '0;
        bus.idx_ready   = 1'b0;
        tick();
        tick();
        chk("rst_match_ready", 32'(bus.match_ready), 1);
        chk("rst_idx_valid",   32'(bus.idx_valid),   0);
        chk("rst_idx",         32'(bus.idx),         0);
        chk("rst_idx_last",    32'(bus.idx_last),    0);
        chk("rst_hit_count",   32'(bus.hit_count),   0);
        chk("rst_miss",        32'(bus.miss),        0);
        reset = 1'b0;
        tick();

        // Three hits, streamed back to back
        bus.idx_ready   = 1'b1;
        bus.match_valid = 1'b1;
        bus.matched     = 20'h00070;
`ifdef TCAM_WALK_MSB_FIRST_EN
        push(6, 0, 3); push(5, 0, 3); push(4, 1, 3);
`else
        push(4, 0, 3); push(5, 0, 3); push(6, 1, 3);
`endif
        chk("t1_ready_before", 32'(bus.match_ready), 1);
        tick();
        bus.match_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t1_ready_walk", 32'(bus.match_ready), 0);
            tick();
        end
        chk("t1_ready_after", 32'(bus.match_ready), 1);
        chk("t1_valid_after", 32'(bus.idx_valid),   0);
        chk("t1_hit_count",   32'(bus.hit_count),   3);

        // All-zero vector
        bus.match_valid = 1'b1;
        bus.matched     = '0;
        tick();
        bus.match_valid = 1'b0;
        chk("t2_miss",        32'(bus.miss),        1);
        chk("t2_idx_valid",   32'(bus.idx_valid),   0);
        chk("t2_hit_count",   32'(bus.hit_count),   0);
        chk("t2_match_ready", 32'(bus.match_ready), 1);
        tick();
        chk("t2_miss_clear",  32'(bus.miss),        0);
        chk("t2_idx_valid2",  32'(bus.idx_valid),   0);

        // Backpressure on a two-hit vector spanning both ends
        bus.idx_ready   = 1'b0;
        bus.match_valid = 1'b1;
        bus.matched     = 20'h80001;
`ifdef TCAM_WALK_MSB_FIRST_EN
        push(19, 0, 2); push(0, 1, 2);
`else
        push(0, 0, 2); push(19, 1, 2);
`endif
        tick();
        bus.match_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_hold_valid", 32'(bus.idx_valid), 1);
`ifdef TCAM_WALK_MSB_FIRST_EN
            chk("t3_hold_idx",   32'(bus.idx),       19);
`else
            chk("t3_hold_idx",   32'(bus.idx),       0);
`endif
            chk("t3_hold_last",  32'(bus.idx_last),  0);
            tick();
        end
        bus.idx_ready = 1'b1;
        tick();
        tick();
        chk("t3_ready_after", 32'(bus.match_ready), 1);

        // Full vector; a lookup during the walk must be ignored
        bus.match_valid = 1'b1;
        bus.matched     = 20'hFFFFF;
        for (int i = 0; i < N; i++) begin
`ifdef TCAM_WALK_MSB_FIRST_EN
            push(N - 1 - i, (i == N - 1) ? 1 : 0, 20);
`else
            push(i, (i == N - 1) ? 1 : 0, 20);
`endif
        end
        tick();
        bus.matched = 20'h00001;
        chk("t4_ready_walk", 32'(bus.match_ready), 0);
        tick();
        bus.match_valid = 1'b0;
        repeat (19) tick();
        chk("t4_ready_after", 32'(bus.match_ready), 1);
        chk("t4_hit_count",   32'(bus.hit_count),   20);
        chk("t4_queue_empty", 32'(exp_q.size()),    0);

        // Reset mid-walk abandons the remaining index
        bus.match_valid = 1'b1;
        bus.matched     = 20'h00C00;
`ifdef TCAM_WALK_MSB_FIRST_EN
        push(11, 0, 2);
`else
        push(10, 0, 2);
`endif
        tick();
        bus.match_valid = 1'b0;
        tick();
        bus.idx_ready = 1'b0;
        reset         = 1'b1;
        tick();
        chk("t5_idx_valid",   32'(bus.idx_valid),   0);
        chk("t5_hit_count",   32'(bus.hit_count),   0);
        chk("t5_match_ready", 32'(bus.match_ready), 1);
        reset         = 1'b0;
        bus.idx_ready = 1'b1;
        repeat (4) tick();
        chk("t5_no_resume",   32'(bus.idx_valid),   0);

        // Back-to-back captures
        bus.match_valid = 1'b1;
        bus.matched     = 20'h00001;
        push(0, 1, 1);
        tick();
        bus.match_valid = 1'b0;
        tick();
        chk("t6_ready_first", 32'(bus.match_ready), 1);
        bus.match_valid = 1'b1;
        bus.matched     = 20'h00002;
        push(1, 1, 1);
        tick();
        bus.match_valid = 1'b0;
        chk("t6_idx_valid",   32'(bus.idx_valid),   1);
        chk("t6_idx",         32'(bus.idx),         1);
        tick();
        tick();
        chk("final_queue_empty", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
